alu_req_arbiter: RTL and testbench

- Shares the single ALU datapath between two requesters: Decoder_unit plus the Arith, Logic, CMP and Shift units.
- Arbitrates by round robin and issues one operation at a time.
- Waits for the ALU result, with a timeout, then returns result and requester ID over a valid/ready response channel.
- Sits between the command sources (sequencer, debug port) and the ALU top.

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/alu_req_arbiter_if.sv | 53 +++++
 rtl/rr_arb2.sv | 45 ++++
 rtl/alu_req_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_req_arbiter shared definitions.
// State encoding, unit-class constants, default widths.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int FUN_W_DEF    = 4;
  localparam int WAIT_MAX_DEF = 8;
  localparam int CNT_W        = 8;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_RES = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  function automatic logic [1:0] fun_class(
    input logic [FUN_W_DEF-1:0] fun
  );
    return fun[FUN_W_DEF-1 -: 2];
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter bus bundle.
// Request, ALU and response channels in one interface.
interface alu_req_arbiter_if
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FUN_W  = FUN_W_DEF
);

  logic              REQ0_VALID;
  logic              REQ0_READY;
  logic [FUN_W-1:0]  REQ0_FUN;
  logic [DATA_W-1:0] REQ0_A;
  logic [DATA_W-1:0] REQ0_B;

  logic              REQ1_VALID;
  logic              REQ1_READY;
  logic [FUN_W-1:0]  REQ1_FUN;
  logic [DATA_W-1:0] REQ1_A;
  logic [DATA_W-1:0] REQ1_B;

  logic              ALU_EN;
  logic [FUN_W-1:0]  ALU_FUN;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_B;
  logic [DATA_W-1:0] ALU_OUT;
  logic              ALU_OUT_VALID;

  logic              RSP_VALID;
  logic              RSP_READY;
  logic              RSP_ID;
  logic [DATA_W-1:0] RSP_DATA;
  logic              RSP_ERR;

  modport master (
    input  REQ0_VALID, REQ0_FUN, REQ0_A, REQ0_B,
    input  REQ1_VALID, REQ1_FUN, REQ1_A, REQ1_B,
    input  ALU_OUT, ALU_OUT_VALID, RSP_READY,
    output REQ0_READY, REQ1_READY,
    output ALU_EN, ALU_FUN, ALU_A, ALU_B,
    output RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );

  modport slave (
    output REQ0_VALID, REQ0_FUN, REQ0_A, REQ0_B,
    output REQ1_VALID, REQ1_FUN, REQ1_A, REQ1_B,
    output ALU_OUT, ALU_OUT_VALID, RSP_READY,
    input  REQ0_READY, REQ1_READY,
    input  ALU_EN, ALU_FUN, ALU_A, ALU_B,
    input  RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Combinational one-hot grant, registered priority pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant the lone requester, or the pointer's pick on contention.
  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = ptr_q ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  // On an accepted grant, priority passes to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = gnt_o[0];
    end
  end

  // Pointer register; reset gives requester 0 first priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters.
// Round-robin accept, issue, wait with timeout, respond.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FUN_W    = FUN_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input logic CLK,
  input logic RST,
  alu_req_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WAIT_MAX - 1);

  logic [1:0]        state_q, state_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic       idle;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       ptr;
  logic       win;
  logic       adv;

  assign idle = (state_q == S_IDLE);
  assign req  = {bus.REQ1_VALID, bus.REQ0_VALID}
              & {2{idle}};
  assign adv  = |gnt;
  assign win  = (req == 2'b11) ? ptr : gnt[1];

  rr_arb2 u_arb (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (req),
    .adv_i (adv),
    .gnt_o (gnt),
    .ptr_o (ptr)
  );

  // Next-state and capture logic for the single in-flight op.
  always_comb begin
    state_d = state_q;
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (adv) begin
          fun_d   = win ? bus.REQ1_FUN : bus.REQ0_FUN;
          a_d     = win ? bus.REQ1_A   : bus.REQ0_A;
          b_d     = win ? bus.REQ1_B   : bus.REQ0_B;
          id_d    = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.ALU_OUT_VALID) begin
          rdata_d = bus.ALU_OUT;
          rerr_d  = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers; reset aborts any op.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.REQ0_READY = gnt[0];
  assign bus.REQ1_READY = gnt[1];
  assign bus.ALU_EN     = (state_q == S_ISSUE);
  assign bus.ALU_FUN    = fun_q;
  assign bus.ALU_A      = a_q;
  assign bus.ALU_B      = b_q;
  assign bus.RSP_VALID  = (state_q == S_RESP);
  assign bus.RSP_ID     = id_q;
  assign bus.RSP_DATA   = rdata_q;
  assign bus.RSP_ERR    = rerr_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter.
// Table vectors, reset corner case, random ops vs model.
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int WM = 8;

  logic CLK = 1'b0;
  logic RST;

  alu_req_arbiter_if #(.DATA_W(DW), .FUN_W(FW)) bus ();

  alu_req_arbiter #(
    .DATA_W(DW), .FUN_W(FW), .WAIT_MAX(WM)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          v0;
    bit          v1;
    logic [3:0]  f0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [3:0]  f1;
    logic [15:0] a1;
    logic [15:0] b1;
    int          dly;
    logic [15:0] res;
    int          stall;
    bit          eid;
    logic [15:0] edata;
    bit          eerr;
    int          ewait;
  } vec_t;

  int tests = 0;
  int fails = 0;
  bit ptr_m;
  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    bus.REQ0_VALID    = 1'b0;
    bus.REQ0_FUN      = '0;
    bus.REQ0_A        = '0;
    bus.REQ0_B        = '0;
    bus.REQ1_VALID    = 1'b0;
    bus.REQ1_FUN      = '0;
    bus.REQ1_A        = '0;
    bus.REQ1_B        = '0;
    bus.ALU_OUT       = '0;
    bus.ALU_OUT_VALID = 1'b0;
    bus.RSP_READY     = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_alu_en"}, 32'(bus.ALU_EN), 0);
    chk({tag, "_alu_fun"}, 32'(bus.ALU_FUN), 0);
    chk({tag, "_alu_a"}, 32'(bus.ALU_A), 0);
    chk({tag, "_alu_b"}, 32'(bus.ALU_B), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.RSP_VALID), 0);
    chk({tag, "_rsp_id"}, 32'(bus.RSP_ID), 0);
    chk({tag, "_rsp_data"}, 32'(bus.RSP_DATA), 0);
    chk({tag, "_rsp_err"}, 32'(bus.RSP_ERR), 0);
    chk({tag, "_ready"},
        32'({bus.REQ1_READY, bus.REQ0_READY}), 0);
  endtask

  // One full operation: accept, issue, wait, respond.
  task automatic do_op(input vec_t v);
    logic [3:0]  ef;
    logic [15:0] ea;
    logic [15:0] eb;
    int n;
    ef = v.eid ? v.f1 : v.f0;
    ea = v.eid ? v.a1 : v.a0;
    eb = v.eid ? v.b1 : v.b0;
    bus.REQ0_VALID    = v.v0;
    bus.REQ0_FUN      = v.f0;
    bus.REQ0_A        = v.a0;
    bus.REQ0_B        = v.b0;
    bus.REQ1_VALID    = v.v1;
    bus.REQ1_FUN      = v.f1;
    bus.REQ1_A        = v.a1;
    bus.REQ1_B        = v.b1;
    bus.RSP_READY     = 1'b0;
    bus.ALU_OUT_VALID = 1'b0;
    #1;
    chk("grant", 32'({bus.REQ1_READY, bus.REQ0_READY}),
        v.eid ? 32'd2 : 32'd1);
    step();
    if (v.eid) bus.REQ1_VALID = 1'b0;
    else       bus.REQ0_VALID = 1'b0;
    #1;
    chk("issue_en", 32'(bus.ALU_EN), 1);
    chk("issue_fun", 32'(bus.ALU_FUN), 32'(ef));
    chk("issue_a", 32'(bus.ALU_A), 32'(ea));
    chk("issue_b", 32'(bus.ALU_B), 32'(eb));
    chk("busy_ready",
        32'({bus.REQ1_READY, bus.REQ0_READY}), 0);
    n = 0;
    while (n < 40) begin
      step();
      bus.ALU_OUT_VALID = (n == v.dly);
      bus.ALU_OUT = (n == v.dly) ? v.res
                                 : 16'($urandom);
      #1;
      if (bus.RSP_VALID) break;
      if (n == 0) chk("en_drop", 32'(bus.ALU_EN), 0);
      n++;
    end
    bus.ALU_OUT_VALID = 1'b0;
    chk("wait_cycles", 32'(n), 32'(v.ewait));
    chk("rsp_id", 32'(bus.RSP_ID), 32'(v.eid));
    chk("rsp_data", 32'(bus.RSP_DATA), 32'(v.edata));
    chk("rsp_err", 32'(bus.RSP_ERR), 32'(v.eerr));
    for (int s = 0; s < v.stall; s++) begin
      step();
      chk("stall_valid", 32'(bus.RSP_VALID), 1);
      chk("stall_id", 32'(bus.RSP_ID), 32'(v.eid));
      chk("stall_data", 32'(bus.RSP_DATA),
          32'(v.edata));
      chk("stall_err", 32'(bus.RSP_ERR), 32'(v.eerr));
      chk("stall_ready",
          32'({bus.REQ1_READY, bus.REQ0_READY}), 0);
    end
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    #1;
    chk("rsp_drop", 32'(bus.RSP_VALID), 0);
  endtask

  // Reference model: who wins, what comes back, how long.
  task automatic model(inout vec_t v);
    bit hit;
    v.eid = (v.v0 && v.v1) ? ptr_m : v.v1;
    ptr_m = ~v.eid;
    hit   = (v.dly >= 0) && (v.dly < WM);
    v.ewait = hit ? v.dly + 1 : WM;
    v.edata = hit ? v.res : 16'h0;
    v.eerr  = !hit;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    int   k;
    tbl[0] = '{1, 0, 4'h0, 16'd5, 16'd3, 4'h0, 0, 0,
               0, 16'd8, 0, 0, 16'd8, 0, 1};
    tbl[1] = '{1, 1, 4'h1, 16'd10, 16'd4, 4'h4,
               16'hF0F0, 16'h0FF0, 0, 16'h00F0, 0,
               1, 16'h00F0, 0, 1};
    tbl[2] = '{1, 1, 4'h1, 16'd10, 16'd4, 4'h4,
               16'hF0F0, 16'h0FF0, 2, 16'd6, 0,
               0, 16'd6, 0, 3};
    tbl[3] = '{1, 1, 4'h1, 16'd10, 16'd4, 4'hC,
               16'd1, 16'd4, 3, 16'h0010, 0,
               1, 16'h0010, 0, 4};
    tbl[4] = '{1, 1, 4'h8, 16'd7, 16'd7, 4'hC,
               16'd1, 16'd4, -1, 16'h1111, 0,
               0, 16'h0, 1, 8};
    tbl[5] = '{0, 1, 4'h0, 0, 0, 4'h2, 16'd1, 16'd2,
               7, 16'h00AA, 0, 1, 16'h00AA, 0, 8};
    tbl[6] = '{0, 1, 4'h0, 0, 0, 4'h3, 16'd9, 16'd9,
               8, 16'h5555, 0, 1, 16'h0, 1, 8};
    tbl[7] = '{1, 0, 4'h5, 16'h00FF, 16'h0F0F, 4'h0,
               0, 0, 1, 16'h1234, 5, 0, 16'h1234, 0, 2};
    tbl[8] = '{1, 1, 4'h6, 16'd3, 16'd3, 4'hD,
               16'hBEEF, 16'd0, 0, 16'hBEEF, 2,
               1, 16'hBEEF, 0, 1};

    clr_inputs();
    RST = 1'b1;
    step();
    step();
    chk_zero("reset");
    RST = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i]);
    end

    bus.REQ0_VALID = 1'b1;
    bus.REQ0_FUN   = 4'h2;
    bus.REQ0_A     = 16'd40;
    bus.REQ0_B     = 16'd2;
    #1;
    chk("abort_grant",
        32'({bus.REQ1_READY, bus.REQ0_READY}), 1);
    step();
    bus.REQ0_VALID = 1'b0;
    step();
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_zero("abort");
    bus.ALU_OUT       = 16'h0055;
    bus.ALU_OUT_VALID = 1'b1;
    step();
    bus.ALU_OUT_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("late_valid_ignored", 32'(bus.RSP_VALID), 0);
      step();
    end

    ptr_m = 1'b0;
    r = '{1, 1, 4'h7, 16'd1, 16'd2, 4'h9, 16'd3,
          16'd4, 0, 16'h0077, 0, 0, 0, 0, 0};
    model(r);
    do_op(r);

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 2));
      r.v0 = (k != 1);
      r.v1 = (k != 0);
      r.f0 = 4'($urandom);
      r.a0 = 16'($urandom);
      r.b0 = 16'($urandom);
      r.f1 = 4'($urandom);
      r.a1 = 16'($urandom);
      r.b1 = 16'($urandom);
      k = int'($urandom_range(0, 11));
      r.dly = (k == 11) ? -1 : k;
      r.res = 16'($urandom);
      r.stall = int'($urandom_range(0, 3));
      model(r);
      do_op(r);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
